// File: rtl/song_reader_pkg.sv
// Shared definitions for the song sequencer: field widths, FSM state
// encoding and the song image that song_rom serves.
//
// Song image (address = {song, idx}, word = {note, dur}):
//   song 0 : (12,4) (20,2) marker
//   song 1 : (0,5)  (7,1)  marker            -- note 0 is a rest
//   song 2 : (33,7) (40,9) marker
//   song 3 : 32 entries, slot i = (63-i, i+1), no marker
// Every slot not listed above holds 0, which reads as an end-of-song marker.
package song_reader_pkg;

    localparam int SONG_BITS = 2;
    localparam int IDX_BITS  = 5;
    localparam int NOTE_W    = 6;
    localparam int DUR_W     = 6;
    localparam int ADDR_W    = SONG_BITS + IDX_BITS;
    localparam int ROM_W     = NOTE_W + DUR_W;

    localparam logic [DUR_W-1:0]    END_MARKER = '0;
    localparam logic [IDX_BITS-1:0] IDX_LAST   = '1;
    localparam logic [IDX_BITS-1:0] IDX_ONE    = IDX_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LOAD     = 3'd2,
        S_ANNOUNCE = 3'd3,
        S_GUARD    = 3'd4,
        S_PLAY     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    function automatic logic [ROM_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
        logic [SONG_BITS-1:0] s;
        logic [IDX_BITS-1:0]  i;
        logic [NOTE_W-1:0]    i6;
        s  = addr[ADDR_W-1:IDX_BITS];
        i  = addr[IDX_BITS-1:0];
        i6 = {1'b0, i};
        rom_word = '0;
        case (s)
            2'd0: begin
                case (i)
                    5'd0:    rom_word = {6'd12, 6'd4};
                    5'd1:    rom_word = {6'd20, 6'd2};
                    default: rom_word = '0;
                endcase
            end
            2'd1: begin
                case (i)
                    5'd0:    rom_word = {6'd0, 6'd5};
                    5'd1:    rom_word = {6'd7, 6'd1};
                    default: rom_word = '0;
                endcase
            end
            2'd2: begin
                case (i)
                    5'd0:    rom_word = {6'd33, 6'd7};
                    5'd1:    rom_word = {6'd40, 6'd9};
                    default: rom_word = '0;
                endcase
            end
            default: rom_word = {6'd63 - i6, i6 + 6'd1};
        endcase
    endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous-read song ROM, one cycle of latency.
// Ports:
//   clk   in   system clock
//   addr  in   {song, idx}
//   dout  out  {note, dur}, valid the cycle after addr is presented
module song_rom
    import song_reader_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROM_W-1:0]  dout
);

    always_ff @(posedge clk) begin
        dout <= rom_word(addr);
    end

endmodule

// File: rtl/song_reader.sv
// Song sequencer feeding note_player. Walks the selected song one ROM entry
// per note, loads each note/duration pair with a one-cycle new_note strobe,
// waits for note_done, and raises song_done at the end marker or after the
// last slot.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low
//   play       in   1 = advance, 0 = hold in PLAY
//   song       in   song select; any change restarts at slot 0
//   note_done  in   note_player done level (high while idle)
//   note       out  note code to load (registered)
//   duration   out  duration to load (registered)
//   new_note   out  load strobe, one cycle wide
//   song_done  out  level, held until song change or reset
module song_reader
    import song_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play,
    input  logic [SONG_BITS-1:0] song,
    input  logic                 note_done,
    output logic [NOTE_W-1:0]    note,
    output logic [DUR_W-1:0]     duration,
    output logic                 new_note,
    output logic                 song_done
);

    state_t                 state_q;
    logic [IDX_BITS-1:0]    idx_q;
    logic [IDX_BITS-1:0]    idx_d;
    logic [SONG_BITS-1:0]   song_q;
    logic [NOTE_W-1:0]      note_q;
    logic [DUR_W-1:0]       dur_q;
    logic                   new_note_q;
    logic                   song_done_q;

    logic [ADDR_W-1:0]      rom_addr;
    logic [ROM_W-1:0]       rom_dout;
    logic [NOTE_W-1:0]      rom_note;
    logic [DUR_W-1:0]       rom_dur;

    // The address is always driven from the current slot; it only matters
    // in FETCH, and dout is consumed in LOAD.
    assign rom_addr = {song_q, idx_q};
    assign rom_note = rom_dout[ROM_W-1:DUR_W];
    assign rom_dur  = rom_dout[DUR_W-1:0];
    assign idx_d    = idx_q + IDX_ONE;

    song_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .dout (rom_dout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            song_q      <= song;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else if (song != song_q) begin
            // A new selection outranks everything else this cycle,
            // including an arriving note_done. note/duration are left
            // alone: without a strobe they are never consumed.
            state_q     <= S_IDLE;
            idx_q       <= '0;
            song_q      <= song;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            new_note_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (play) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    if (rom_dur == END_MARKER) begin
                        state_q     <= S_DONE;
                        song_done_q <= 1'b1;
                    end else begin
                        note_q     <= rom_note;
                        dur_q      <= rom_dur;
                        new_note_q <= 1'b1;
                        state_q    <= S_ANNOUNCE;
                    end
                end
                S_ANNOUNCE: begin
                    state_q <= S_GUARD;
                end
                S_GUARD: begin
                    // note_done is stale here: note_player only restarts
                    // its timer the cycle after the load.
                    state_q <= S_PLAY;
                end
                S_PLAY: begin
                    if (note_done && play) begin
                        if (idx_q == IDX_LAST) begin
                            state_q     <= S_DONE;
                            song_done_q <= 1'b1;
                        end else begin
                            idx_q   <= idx_d;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    song_done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign note      = note_q;
    assign duration  = dur_q;
    assign new_note  = new_note_q;
    assign song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
module tb_song_reader;
    import song_reader_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play = 1'b0;
    logic [1:0] song = 2'd0;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    song_reader dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    // note_done source: 0 = note_player model, 1 = forced high, 2 = forced low
    int         nd_mode = 0;
    logic [7:0] np_cnt  = 8'd0;
    logic       np_pend = 1'b0;

    assign note_done = (nd_mode == 1) ? 1'b1 :
                       (nd_mode == 2) ? 1'b0 : (np_cnt == 8'd0);

    // note_player model: timer starts the cycle after the load strobe,
    // counts down one per cycle while play is high.
    always @(posedge clk) begin
        if (!reset) begin
            np_cnt  <= 8'd0;
            np_pend <= 1'b0;
        end else begin
            np_pend <= new_note;
            if (np_pend)
                np_cnt <= {2'b00, duration};
            else if (play && np_cnt != 8'd0)
                np_cnt <= np_cnt - 8'd1;
        end
    end

    int pulse_cnt = 0;
    always @(negedge clk) begin
        if (new_note === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [1:0] s);
        song  = s;
        play  = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_pulse(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (new_note !== 1'b1 && n < max);
        if (new_note !== 1'b1) check_val("pulse_timeout", 0, 1);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (song_done !== 1'b1 && n < max);
        if (song_done !== 1'b1) check_val("done_timeout", 0, 1);
    endtask

    int n;
    int base;

    initial begin
        // 1: reset, then idle with play low
        nd_mode = 1;
        do_reset(2'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("t1_new_note", int'(new_note), 0);
            check_val("t1_song_done", int'(song_done), 0);
            check_val("t1_note", int'(note), 0);
            check_val("t1_dur", int'(duration), 0);
        end
        check_val("t1_state", int'(dut.state_q), int'(S_IDLE));

        // 2: song 0 with the note_player model
        nd_mode = 0;
        do_reset(2'd0);
        base = pulse_cnt;
        play = 1'b1;
        wait_pulse(10, n);
        check_val("t2_lat", n, 3);
        check_val("t2_note0", int'(note), 12);
        check_val("t2_dur0", int'(duration), 4);
        wait_pulse(30, n);
        check_val("t2_gap", n, 9);
        check_val("t2_note1", int'(note), 20);
        check_val("t2_dur1", int'(duration), 2);
        wait_done(20, n);
        check_val("t2_done_lat", n, 7);
        repeat (15) step();
        check_val("t2_pulses", pulse_cnt - base, 2);
        check_val("t2_done_hold", int'(song_done), 1);

        // 3: note_done stuck high, song 1 (rest first)
        nd_mode = 1;
        do_reset(2'd1);
        base = pulse_cnt;
        play = 1'b1;
        wait_pulse(10, n);
        check_val("t3_lat", n, 3);
        check_val("t3_note0", int'(note), 0);
        check_val("t3_dur0", int'(duration), 5);
        wait_pulse(10, n);
        check_val("t3_round", n, 5);
        check_val("t3_note1", int'(note), 7);
        check_val("t3_dur1", int'(duration), 1);
        wait_done(10, n);
        check_val("t3_done_lat", n, 5);
        repeat (10) step();
        check_val("t3_pulses", pulse_cnt - base, 2);

        // 4: pause in PLAY with note_done high
        nd_mode = 1;
        do_reset(2'd2);
        play = 1'b1;
        wait_pulse(10, n);
        check_val("t4_note0", int'(note), 33);
        play = 1'b0;
        step();
        base = pulse_cnt;
        repeat (20) step();
        check_val("t4_hold_pulses", pulse_cnt - base, 0);
        check_val("t4_hold_state", int'(dut.state_q), int'(S_PLAY));
        play = 1'b1;
        wait_pulse(10, n);
        check_val("t4_resume_lat", n, 3);
        check_val("t4_note1", int'(note), 40);
        check_val("t4_dur1", int'(duration), 9);

        // 5: song change collides with note_done
        nd_mode = 2;
        do_reset(2'd0);
        play = 1'b1;
        wait_pulse(10, n);
        check_val("t5_note0", int'(note), 12);
        step();
        step();
        check_val("t5_in_play", int'(dut.state_q), int'(S_PLAY));
        song    = 2'd2;
        nd_mode = 1;
        step();
        check_val("t5_state", int'(dut.state_q), int'(S_IDLE));
        check_val("t5_idx", int'(dut.idx_q), 0);
        check_val("t5_song_done", int'(song_done), 0);
        check_val("t5_new_note", int'(new_note), 0);
        check_val("t5_note_kept", int'(note), 12);
        wait_pulse(10, n);
        check_val("t5_lat", n, 3);
        check_val("t5_note", int'(note), 33);
        check_val("t5_dur", int'(duration), 7);

        // 6: full 32-slot song, no wrap
        nd_mode = 1;
        do_reset(2'd3);
        base = pulse_cnt;
        play = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wait_pulse(8, n);
            check_val("t6_gap", n, (i == 0) ? 3 : 5);
            check_val("t6_note", int'(note), 63 - i);
            check_val("t6_dur", int'(duration), i + 1);
        end
        wait_done(10, n);
        check_val("t6_done_lat", n, 3);
        repeat (10) step();
        check_val("t6_pulses", pulse_cnt - base, 32);
        check_val("t6_idx", int'(dut.idx_q), 31);
        check_val("t6_state", int'(dut.state_q), int'(S_DONE));
        check_val("t6_done_hold", int'(song_done), 1);
        song = 2'd0;
        step();
        check_val("t6_chg_done", int'(song_done), 0);
        check_val("t6_chg_idx", int'(dut.idx_q), 0);

        // 7: reset lands while a load is pending
        nd_mode = 1;
        do_reset(2'd0);
        play = 1'b1;
        step();
        step();
        check_val("t7_in_load", int'(dut.state_q), int'(S_LOAD));
        reset = 1'b0;
        step();
        check_val("t7_new_note", int'(new_note), 0);
        check_val("t7_note", int'(note), 0);
        check_val("t7_state", int'(dut.state_q), int'(S_IDLE));
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
